// File: rtl/branch_history_unit.sv
// rtl/branch_history_unit.sv - gshare index generation, in-flight branch FIFO and global history recovery
// Optional BHU_PERF_CNT_EN adds br_cnt/mis_cnt resolve and mispredict counters.
module branch_history_unit #(
    parameter int HIST_W = 10,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fetch_valid,
    input  logic [31:0]                fetch_pc,
    input  logic                       fetch_predict,
    output logic [HIST_W-1:0]          pred_index,
    output logic                       fetch_ready,
    input  logic                       resolve_valid,
    input  logic                       resolve_taken,
    output logic                       upd_valid,
    output logic [HIST_W-1:0]          upd_index,
    output logic                       upd_taken,
    output logic                       mispredict,
    output logic [$clog2(DEPTH):0]     inflight
`ifdef BHU_PERF_CNT_EN
    ,
    output logic [15:0]                br_cnt,
    output logic [15:0]                mis_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [HIST_W-1:0] spec_ghr;
    logic [HIST_W-1:0] arch_ghr;
    logic [HIST_W-1:0] arch_next;
    logic [HIST_W-1:0] idx_mem  [DEPTH];
    logic              pred_mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic do_resolve;
    logic mis_now;
    logic accept;
    logic unused_pc_bits;

    assign unused_pc_bits = ^{fetch_pc[31:HIST_W+2], fetch_pc[1:0]};

    assign pred_index  = fetch_pc[HIST_W+1:2] ^ spec_ghr;
    assign do_resolve  = resolve_valid & (count != '0);
    assign mis_now     = do_resolve & (pred_mem[head] != resolve_taken);
    assign fetch_ready = (count < CNT_W'(DEPTH)) & ~mis_now;
    assign accept      = fetch_valid & fetch_ready;
    assign arch_next   = {arch_ghr[HIST_W-2:0], resolve_taken};
    assign inflight    = count;

    // Entry storage carries no reset; only slots between head and tail are ever read.
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_mem[tail]  <= pred_index;
            pred_mem[tail] <= fetch_predict;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spec_ghr   <= '0;
            arch_ghr   <= '0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            upd_valid  <= 1'b0;
            upd_index  <= '0;
            upd_taken  <= 1'b0;
            mispredict <= 1'b0;
        end else begin
            upd_valid  <= do_resolve;
            mispredict <= mis_now;
            if (do_resolve) begin
                upd_index <= idx_mem[head];
                upd_taken <= resolve_taken;
                arch_ghr  <= arch_next;
            end
            if (mis_now) begin
                // Everything younger than the resolved branch is wrong-path; restart from architectural history.
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                spec_ghr <= arch_next;
            end else begin
                if (accept) begin
                    tail     <= tail + 1'b1;
                    spec_ghr <= {spec_ghr[HIST_W-2:0], fetch_predict};
                end
                if (do_resolve) begin
                    head <= head + 1'b1;
                end
                case ({accept, do_resolve})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

`ifdef BHU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt  <= '0;
            mis_cnt <= '0;
        end else begin
            if (do_resolve && (br_cnt != 16'hFFFF)) begin
                br_cnt <= br_cnt + 16'd1;
            end
            if (mis_now && (mis_cnt != 16'hFFFF)) begin
                mis_cnt <= mis_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_history_unit.sv
// tb/tb_branch_history_unit.sv - scoreboard bench for branch_history_unit against a queue-based model
module tb_branch_history_unit;

    localparam int HIST_W = 10;
    localparam int DEPTH  = 4;
    localparam int MASK   = (1 << HIST_W) - 1;

    logic              clk;
    logic              rst;
    logic              fetch_valid;
    logic [31:0]       fetch_pc;
    logic              fetch_predict;
    logic [HIST_W-1:0] pred_index;
    logic              fetch_ready;
    logic              resolve_valid;
    logic              resolve_taken;
    logic              upd_valid;
    logic [HIST_W-1:0] upd_index;
    logic              upd_taken;
    logic              mispredict;
    logic [2:0]        inflight;
`ifdef BHU_PERF_CNT_EN
    logic [15:0]       br_cnt;
    logic [15:0]       mis_cnt;
`endif

    branch_history_unit #(.HIST_W(HIST_W), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_valid   (fetch_valid),
        .fetch_pc      (fetch_pc),
        .fetch_predict (fetch_predict),
        .pred_index    (pred_index),
        .fetch_ready   (fetch_ready),
        .resolve_valid (resolve_valid),
        .resolve_taken (resolve_taken),
        .upd_valid     (upd_valid),
        .upd_index     (upd_index),
        .upd_taken     (upd_taken),
        .mispredict    (mispredict),
        .inflight      (inflight)
`ifdef BHU_PERF_CNT_EN
        ,
        .br_cnt        (br_cnt),
        .mis_cnt       (mis_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: in-flight branches as a plain queue, histories as integers.
    typedef struct {
        int idx;
        bit pred;
    } entry_t;
    typedef struct {
        int cyc;
        int idx;
        bit taken;
        bit mis;
    } exp_t;

    entry_t inq[$];
    exp_t   expq[$];
    int     m_spec = 0;
    int     m_arch = 0;
    int     m_br   = 0;
    int     m_mis  = 0;

    // Monitor: every update the DUT presents must match the oldest expected one, on time.
    always @(negedge clk) begin
        if (upd_valid) begin
            if (expq.size() == 0) begin
                check("unexpected_upd_valid", 1, 0);
            end else begin
                exp_t e;
                e = expq.pop_front();
                check("upd_cycle", cyc, e.cyc);
                check("upd_index", int'(upd_index), e.idx);
                check("upd_taken", int'(upd_taken), int'(e.taken));
                check("mispredict", int'(mispredict), int'(e.mis));
            end
        end else begin
            if (mispredict) check("mispredict_without_upd", 1, 0);
            if (expq.size() > 0 && expq[0].cyc <= cyc) begin
                check("missing_upd_valid", 0, 1);
                void'(expq.pop_front());
            end
        end
    end

    task automatic step(input bit fv, input logic [31:0] pc, input bit fp, input bit rv, input bit rt);
        bit res, mis, acc;
        int idx;
        fetch_valid   = fv;
        fetch_pc      = pc;
        fetch_predict = fp;
        resolve_valid = rv;
        resolve_taken = rt;
        #1;
        res = rv && (inq.size() > 0);
        mis = res && (inq[0].pred != rt);
        acc = fv && (inq.size() < DEPTH) && !mis;
        idx = ((pc >> 2) ^ m_spec) & MASK;
        check("pred_index", int'(pred_index), idx);
        check("fetch_ready", int'(fetch_ready), int'((inq.size() < DEPTH) && !mis));
        check("inflight", int'(inflight), inq.size());
        if (res) begin
            entry_t h;
            exp_t e;
            h = inq.pop_front();
            m_arch = ((m_arch << 1) | int'(rt)) & MASK;
            e.cyc = cyc + 1; e.idx = h.idx; e.taken = rt; e.mis = mis;
            expq.push_back(e);
            if (m_br < 16'hFFFF) m_br++;
            if (mis && m_mis < 16'hFFFF) m_mis++;
        end
        if (mis) begin
            inq.delete();
            m_spec = m_arch;
        end else if (acc) begin
            entry_t n;
            n.idx = idx; n.pred = fp;
            inq.push_back(n);
            m_spec = ((m_spec << 1) | int'(fp)) & MASK;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fetch_valid = 1'b0;
        resolve_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        inq.delete();
        m_spec = 0; m_arch = 0; m_br = 0; m_mis = 0;
        check("rst_inflight", int'(inflight), 0);
        check("rst_upd_valid", int'(upd_valid), 0);
        check("rst_upd_index", int'(upd_index), 0);
        check("rst_upd_taken", int'(upd_taken), 0);
        check("rst_mispredict", int'(mispredict), 0);
`ifdef BHU_PERF_CNT_EN
        check("rst_br_cnt", int'(br_cnt), 0);
        check("rst_mis_cnt", int'(mis_cnt), 0);
`endif
    endtask

    initial begin
        rst = 1'b1;
        fetch_valid = 1'b0; fetch_pc = '0; fetch_predict = 1'b0;
        resolve_valid = 1'b0; resolve_taken = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();
        fetch_pc = 32'h0;
        #1;
        check("rst_fetch_ready", int'(fetch_ready), 1);
        check("rst_pred_index", int'(pred_index), 0);

        // First lookup and correct resolve.
        fetch_valid = 1'b1; fetch_pc = 32'h40; fetch_predict = 1'b1;
        #1;
        check("tp1_pred_index", int'(pred_index), 'h010);
        step(1, 32'h40, 1, 0, 0);
        check("tp1_inflight", int'(inflight), 1);
        check("tp1_next_index", int'(pred_index), 'h011);
        step(0, 32'h40, 0, 1, 1);
        check("tp2_upd_valid", int'(upd_valid), 1);
        check("tp2_upd_index", int'(upd_index), 'h010);
        check("tp2_mispredict", int'(mispredict), 0);
        check("tp2_inflight", int'(inflight), 0);

        // Fill to DEPTH; further fetches refused even with a concurrent resolve.
        for (int i = 0; i < DEPTH; i++) step(1, $urandom, 1, 0, 0);
        check("full_ready", int'(fetch_ready), 0);
        step(1, 32'h100, 0, 0, 0);
        check("full_inflight", int'(inflight), 4);
        step(1, 32'h104, 0, 1, 1);
        check("full_after_resolve_ready", int'(fetch_ready), 1);
        check("full_after_resolve_inflight", int'(inflight), 3);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1);

        // Mispredict recovery from a clean history.
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 32'h0, 1, 0, 0);
        fetch_pc = 32'h0;
        #1;
        check("mis_spec_ghr", int'(pred_index), 'h007);
        step(1, 32'h0, 1, 1, 0);
        check("mis_pulse", int'(mispredict), 1);
        check("mis_upd_taken", int'(upd_taken), 0);
        check("mis_inflight", int'(inflight), 0);
        check("mis_restored_ghr", int'(pred_index), 'h000);
        check("mis_ready", int'(fetch_ready), 1);
        step(0, 32'h0, 0, 0, 0);
        check("mis_one_cycle", int'(mispredict), 0);

        // Resolve with nothing in flight.
        step(0, 32'h0, 0, 1, 1);
        check("empty_upd_valid", int'(upd_valid), 0);
        check("empty_mispredict", int'(mispredict), 0);
        check("empty_ghr", int'(pred_index), 'h000);

        // Reset discards in-flight entries.
        step(1, 32'h20, 1, 0, 0);
        step(1, 32'h24, 0, 0, 0);
        do_reset();
        step(0, 32'h0, 0, 0, 0);
        check("post_rst_upd_valid", int'(upd_valid), 0);

        // Random traffic; outcomes usually follow the prediction so the FIFO fills.
        for (int i = 0; i < 3000; i++) begin
            bit rt;
            rt = ($urandom_range(0, 7) == 0) ? 1'($urandom) :
                 (inq.size() > 0 ? inq[0].pred : 1'($urandom));
            step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom),
                 1'($urandom_range(0, 2) == 0), rt);
        end
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
`ifdef BHU_PERF_CNT_EN
        check("br_cnt", int'(br_cnt), m_br);
        check("mis_cnt", int'(mis_cnt), m_mis);
`endif
        check("pending_updates", expq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
